cpu_phase_sequencer: RTL

Upstream stage of the instruction-cycle controller in the VeriRisc-style CPU.
Generates the 3-bit phase sequence that the controller decodes, and holds the instruction register that supplies opcode and operand.
Supplies the accumulator zero flag.
Owns run, single-step and halt control of the processor and counts retired instructions.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_phase_sequencer_if.sv | 30 +++
 rtl/cpu_phase_counter.sv | 29 ++
 rtl/cpu_phase_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU phase sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // True while an instruction is being executed (continuous or single step)
    function automatic logic is_active(state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// Control/status bundle between the sequencer and the instruction-cycle controller.
interface cpu_phase_sequencer_if #(
    parameter int IW   = 8,
    parameter int OPW  = 3,
    parameter int CNTW = 16
);
    logic              run;
    logic              step;
    logic              halt;
    logic              ld_ir;
    logic [IW-1:0]     instr_in;
    logic [IW-1:0]     ac_in;
    logic [2:0]        phase;
    logic [OPW-1:0]    opcode;
    logic [IW-OPW-1:0] operand;
    logic              zero;
    logic              running;
    logic              halted;
    logic [CNTW-1:0]   instr_count;

    modport slave (
        input  run, step, halt, ld_ir, instr_in, ac_in,
        output phase, opcode, operand, zero, running, halted, instr_count
    );

    modport master (
        output run, step, halt, ld_ir, instr_in, ac_in,
        input  phase, opcode, operand, zero, running, halted, instr_count
    );
endinterface

// File: rtl/cpu_phase_counter.sv
// 3-bit instruction phase counter with enable, synchronous clear and wrap pulse.
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [2:0] o_phase,
    output logic       o_wrap
);

    logic [2:0] r_phase;

    // Phase register: clear wins over advance; natural 3-bit rollover gives 7->0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_INST_ADDR;
        end else if (i_clr) begin
            r_phase <= PH_INST_ADDR;
        end else if (i_en) begin
            r_phase <= r_phase + 3'd1;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = i_en && !i_clr && (r_phase == PH_STORE);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Phase sequencer: run/step/halt control, instruction register and retired-instruction count.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int IW   = 8,
    parameter int OPW  = 3,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_phase_sequencer_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run_d;
    logic [IW-1:0]   r_ir;
    logic [CNTW-1:0] r_instr_count;
    logic [2:0]      w_phase;
    logic            w_ph_en;
    logic            w_ph_clr;
    logic            w_ph_wrap;
    logic            w_run_rise;

    assign w_run_rise = bus.run && !r_run_d;

    cpu_phase_counter u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_ph_en),
        .i_clr   (w_ph_clr),
        .o_phase (w_phase),
        .o_wrap  (w_ph_wrap)
    );

    // State register plus previous run sample used for restart-from-halt edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_run_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run_d <= bus.run;
        end
    end

    // Next state and phase counter control; halt freezes phase on the edge it is seen
    always_comb begin
        w_state_nxt = r_state;
        w_ph_en     = 1'b0;
        w_ph_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.run) begin
                    w_state_nxt = RUN;
                end else if (bus.step) begin
                    w_state_nxt = STEP;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_ph_en = 1'b1;
                    // run dropping only takes effect once the current instruction retires
                    if ((w_phase == PH_STORE) && !bus.run) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            STEP: begin
                if (bus.halt) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_ph_en = 1'b1;
                    if (w_phase == PH_STORE) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            HALTED: begin
                // a run level held through the halt must not restart the CPU
                if (w_run_rise) begin
                    w_ph_clr    = 1'b1;
                    w_state_nxt = RUN;
                end else if (bus.step) begin
                    w_ph_clr    = 1'b1;
                    w_state_nxt = STEP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Instruction register loads only while executing; a coincident halt still lets it load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (is_active(r_state) && bus.ld_ir) begin
            r_ir <= bus.instr_in;
        end
    end

    // Retired-instruction counter, free-running modulo 2^CNTW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (w_ph_wrap) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign bus.phase       = w_phase;
    assign bus.opcode      = r_ir[IW-1 -: OPW];
    assign bus.operand     = r_ir[IW-OPW-1:0];
    assign bus.zero        = (bus.ac_in == '0);
    assign bus.running     = is_active(r_state);
    assign bus.halted      = (r_state == HALTED);
    assign bus.instr_count = r_instr_count;

endmodule
